// File: rtl/stream_rr_burst_arbiter.sv
// stream_rr_burst_arbiter
//   Round-robin arbiter that merges NUM_IN AXI-Stream producers onto one
//   StreamingFIFO input port. A grant is held for exactly BURST handshakes,
//   because FINN streams carry no TLAST to mark packet boundaries. A granted
//   source whose TVALID stays low for TIMEOUT consecutive cycles is released
//   early.
//
//   Optional feature, enabled by the macro SPACE_CHECK_EN:
//     A new burst is granted only when the downstream FIFO has room for all
//     BURST beats, so a burst never stalls halfway through.
//
//   State table
//     state   | meaning
//     IDLE    | no grant; pick the next valid source after last_ptr
//     GRANT   | grant_id owns the output until BURST beats or a timeout
module stream_rr_burst_arbiter #(
  parameter int NUM_IN     = 4,
  parameter int WIDTH      = 32,
  parameter int BURST      = 16,
  parameter int TIMEOUT    = 64,
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = 5,
  localparam int ID_W      = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
  input  logic                    ap_clk,
  input  logic                    ap_rst,
  input  logic [NUM_IN*WIDTH-1:0] in_V_TDATA,
  input  logic [NUM_IN-1:0]       in_V_TVALID,
  output logic [NUM_IN-1:0]       in_V_TREADY,
  output logic [WIDTH-1:0]        out_V_TDATA,
  output logic                    out_V_TVALID,
  input  logic                    out_V_TREADY,
  input  logic [CNT_W-1:0]        fifo_count,
  output logic                    grant_vld,
  output logic [ID_W-1:0]         grant_id,
  output logic                    release_to
);

  localparam int BEAT_W = (BURST > 1) ? $clog2(BURST) : 1;
  localparam int IDLE_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [ID_W-1:0]   last_ptr_q, last_ptr_d;
  logic [ID_W-1:0]   grant_id_q, grant_id_d;
  logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;

  logic              pick_vld;
  logic [ID_W-1:0]   pick_id;
  logic              space_ok;
  logic              g_valid;
  logic              beat;

  // Elaboration-time parameter sanity.
  if (NUM_IN < 2 || NUM_IN > 16) begin : g_num_in_chk
    $error("stream_rr_burst_arbiter: NUM_IN must be in 2..16");
  end
  if (BURST < 1) begin : g_burst_chk
    $error("stream_rr_burst_arbiter: BURST must be >= 1");
  end

`ifdef SPACE_CHECK_EN
  if (BURST > FIFO_DEPTH) begin : g_depth_chk
    $error("stream_rr_burst_arbiter: BURST must not exceed FIFO_DEPTH");
  end

  // Start a burst only when every one of its beats already fits in the FIFO.
  always_comb begin
    space_ok = ((FIFO_DEPTH - int'(fifo_count)) >= BURST);
  end
`else
  logic unused_fifo_count;

  // Occupancy is irrelevant without the space check.
  always_comb begin
    space_ok          = 1'b1;
    unused_fifo_count = ^fifo_count;
  end
`endif

  // Round-robin pick: first valid source after last_ptr, wrapping to 0.
  always_comb begin
    pick_vld = 1'b0;
    pick_id  = '0;
    for (int k = 1; k <= NUM_IN; k++) begin
      if (!pick_vld && in_V_TVALID[(int'(last_ptr_q) + k) % NUM_IN]) begin
        pick_vld = 1'b1;
        pick_id  = ID_W'((int'(last_ptr_q) + k) % NUM_IN);
      end
    end
  end

  // Next-state logic and the combinational data/handshake pass-through.
  always_comb begin
    state_d      = state_q;
    last_ptr_d   = last_ptr_q;
    grant_id_d   = grant_id_q;
    beat_cnt_d   = beat_cnt_q;
    idle_cnt_d   = idle_cnt_q;
    out_V_TDATA  = '0;
    out_V_TVALID = 1'b0;
    in_V_TREADY  = '0;
    release_to   = 1'b0;
    g_valid      = in_V_TVALID[grant_id_q];
    beat         = g_valid & out_V_TREADY;

    unique case (state_q)
      S_IDLE: begin
        beat_cnt_d = '0;
        idle_cnt_d = '0;
        if (pick_vld && space_ok) begin
          grant_id_d = pick_id;
          state_d    = S_GRANT;
        end
      end

      S_GRANT: begin
        out_V_TDATA             = in_V_TDATA[grant_id_q*WIDTH +: WIDTH];
        out_V_TVALID            = g_valid;
        in_V_TREADY[grant_id_q] = out_V_TREADY;

        // Only a low TVALID counts as idle; downstream backpressure does not.
        if (g_valid) begin
          idle_cnt_d = '0;
        end else if (TIMEOUT > 0) begin
          idle_cnt_d = idle_cnt_q + 1'b1;
        end

        if (beat) begin
          if (beat_cnt_q == BEAT_W'(BURST - 1)) begin
            last_ptr_d = grant_id_q;
            beat_cnt_d = '0;
            idle_cnt_d = '0;
            state_d    = S_IDLE;
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end else if (!g_valid && (TIMEOUT > 0) &&
                     (idle_cnt_q == IDLE_W'(TIMEOUT - 1))) begin
          release_to = 1'b1;
          last_ptr_d = grant_id_q;
          beat_cnt_d = '0;
          idle_cnt_d = '0;
          state_d    = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Nothing may transfer in a reset cycle, even when reset lands mid-burst.
    if (ap_rst) begin
      out_V_TDATA  = '0;
      out_V_TVALID = 1'b0;
      in_V_TREADY  = '0;
      release_to   = 1'b0;
    end
  end

  // State registers; last_ptr starts at NUM_IN-1 so source 0 wins first.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q    <= S_IDLE;
      last_ptr_q <= ID_W'(NUM_IN - 1);
      grant_id_q <= '0;
      beat_cnt_q <= '0;
      idle_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      last_ptr_q <= last_ptr_d;
      grant_id_q <= grant_id_d;
      beat_cnt_q <= beat_cnt_d;
      idle_cnt_q <= idle_cnt_d;
    end
  end

  // Grant status is presented straight from the registers.
  always_comb begin
    grant_vld = (state_q == S_GRANT);
    grant_id  = grant_id_q;
  end

endmodule
